// File: rtl/param_bus_arbiter_if.sv
// Parameter-bus write port: two requesters on the master side, the arbiter on the slave side.
interface param_bus_arbiter_if;
  logic       req0;
  logic       req1;
  logic [2:0] bank0;
  logic [2:0] bank1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       err;
  logic       data_ready;
  logic [2:0] bank_adr;
  logic [7:0] out_data;
  logic       grant;
  logic       busy;

  modport master (
    output req0, bank0, data0, req1, bank1, data1,
    input  ack0, ack1, err, data_ready, bank_adr, out_data, grant, busy
  );

  modport slave (
    input  req0, bank0, data0, req1, bank1, data1,
    output ack0, ack1, err, data_ready, bank_adr, out_data, grant, busy
  );
endinterface

// File: rtl/param_bus_arbiter.sv
// Two-requester round-robin arbiter that sequences one strobed write at a time onto the parameter bus.
// states: IDLE arbitrate | SETUP latch+bank check | STROBE data_ready | HOLD settle | DONE ack | REJECT ack+err
module param_bus_arbiter #(
  parameter int STROBE_LEN = 2,
  parameter int HOLD_LEN   = 4,
  parameter int MAX_BANK   = 5
) (
  input logic                CLOCK_25,
  input logic                reset,
  param_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, REJECT} state_e;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_LEN - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [2:0] bank_q, bank_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       cool0_q, cool1_q;
  logic       elig0, elig1, pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    bank_d  = bank_q;
    data_d  = data_q;
    pick    = 1'b0;
    // a requester acked last cycle sits out one IDLE cycle
    elig0   = bus.req0 && !cool0_q;
    elig1   = bus.req1 && !cool1_q;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          pick    = (elig0 && elig1) ? ~last_q : elig1;
          grant_d = pick;
          last_d  = pick;
          bank_d  = pick ? bus.bank1 : bus.bank0;
          data_d  = pick ? bus.data1 : bus.data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // bank legality is judged on the registered address
        if (32'(bank_q) > 32'(MAX_BANK)) begin
          state_d = REJECT;
        end else begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end
      end
      STROBE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (HOLD_LEN == 0) begin
          state_d = DONE;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == STROBE);
    ack0_d  = ((state_d == DONE) || (state_d == REJECT)) && !grant_d;
    ack1_d  = ((state_d == DONE) || (state_d == REJECT)) && grant_d;
    err_d   = (state_d == REJECT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      bank_q  <= 3'd0;
      data_q  <= 8'd0;
      ready_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cool0_q <= 1'b0;
      cool1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cool0_q <= ack0_q;
      cool1_q <= ack1_q;
    end
  end

  assign bus.data_ready = ready_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.bank_adr   = bank_q;
  assign bus.out_data   = data_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Bench: two builds (2/4 and 1/0 timing) share one stimulus stream; each is checked against a
// transaction-level model every cycle, plus directed vectors and corner sequences.
module tb_param_bus_arbiter;

  localparam int MAXB = 5;

  logic       CLOCK_25 = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] bank0 = 3'd0, bank1 = 3'd0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;

  always #20 CLOCK_25 = ~CLOCK_25;

  param_bus_arbiter_if bus0 ();
  param_bus_arbiter_if bus1 ();

  assign bus0.req0 = req0;   assign bus1.req0 = req0;
  assign bus0.req1 = req1;   assign bus1.req1 = req1;
  assign bus0.bank0 = bank0; assign bus1.bank0 = bank0;
  assign bus0.bank1 = bank1; assign bus1.bank1 = bank1;
  assign bus0.data0 = data0; assign bus1.data0 = data0;
  assign bus0.data1 = data1; assign bus1.data1 = data1;

  param_bus_arbiter #(.STROBE_LEN(2), .HOLD_LEN(4), .MAX_BANK(MAXB)) dut0 (
    .CLOCK_25(CLOCK_25), .reset(rst), .bus(bus0));
  param_bus_arbiter #(.STROBE_LEN(1), .HOLD_LEN(0), .MAX_BANK(MAXB)) dut1 (
    .CLOCK_25(CLOCK_25), .reset(rst), .bus(bus1));

  // {data_ready, ack0, ack1, err, busy, grant, bank_adr, out_data}
  logic [16:0] out_v [2];
  assign out_v[0] = {bus0.data_ready, bus0.ack0, bus0.ack1, bus0.err, bus0.busy,
                     bus0.grant, bus0.bank_adr, bus0.out_data};
  assign out_v[1] = {bus1.data_ready, bus1.ack0, bus1.ack1, bus1.err, bus1.busy,
                     bus1.grant, bus1.bank_adr, bus1.out_data};

  int total = 0;
  int bad   = 0;

  // transaction model: k = cycles elapsed since the granting edge
  bit       m_act  [2];
  int       m_k    [2];
  bit       m_idx  [2];
  bit [2:0] m_bank [2];
  bit [7:0] m_data [2];
  bit       m_last [2];
  bit       m_c0   [2];
  bit       m_c1   [2];

  function automatic int s_len(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int h_len(int i); return (i == 0) ? 4 : 0; endfunction

  function automatic int ack_at(int i);
    return (int'(m_bank[i]) > MAXB) ? 2 : 2 + s_len(i) + h_len(i);
  endfunction

  function automatic logic [16:0] model_vec(int i);
    bit rej, ack, dr;
    rej = int'(m_bank[i]) > MAXB;
    ack = m_act[i] && (m_k[i] == ack_at(i));
    dr  = m_act[i] && !rej && (m_k[i] >= 2) && (m_k[i] <= 1 + s_len(i));
    return {dr, ack && !m_idx[i], ack && m_idx[i], ack && rej, m_act[i], m_idx[i], m_bank[i], m_data[i]};
  endfunction

  task automatic model_step(int i);
    bit ackn, e0, e1, p, c0n, c1n;
    if (rst) begin
      m_act[i] = 0; m_k[i] = 0; m_idx[i] = 0; m_bank[i] = 0; m_data[i] = 0;
      m_last[i] = 1; m_c0[i] = 0; m_c1[i] = 0;
    end else begin
      ackn = m_act[i] && (m_k[i] == ack_at(i));
      c0n  = ackn && !m_idx[i];
      c1n  = ackn && m_idx[i];
      if (m_act[i]) begin
        if (ackn) m_act[i] = 0;
        else m_k[i]++;
      end else begin
        e0 = req0 && !m_c0[i];
        e1 = req1 && !m_c1[i];
        if (e0 || e1) begin
          p = (e0 && e1) ? !m_last[i] : e1;
          m_idx[i]  = p;
          m_last[i] = p;
          m_bank[i] = p ? bank1 : bank0;
          m_data[i] = p ? data1 : data0;
          m_act[i]  = 1;
          m_k[i]    = 1;
        end
      end
      m_c0[i] = c0n;
      m_c1[i] = c1n;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_25);
    model_step(0);
    model_step(1);
    @(negedge CLOCK_25);
    check("model0", 32'(out_v[0]), 32'(model_vec(0)));
    check("model1", 32'(out_v[1]), 32'(model_vec(1)));
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0;
    cyc();
    rst = 0;
  endtask

  typedef struct {
    logic        rst;
    logic        r0;
    logic [2:0]  b0;
    logic [7:0]  d0;
    logic        r1;
    logic [2:0]  b1;
    logic [7:0]  d1;
    logic [16:0] exp;
  } vec_t;

  function automatic logic [16:0] ev(bit dr, bit a0, bit a1, bit er, bit bs, bit g,
                                     bit [2:0] bk, bit [7:0] dt);
    return {dr, a0, a1, er, bs, g, bk, dt};
  endfunction

  function automatic vec_t row(bit rs, bit r0, bit [2:0] b0, bit [7:0] d0,
                               bit r1, bit [2:0] b1, bit [7:0] d1, logic [16:0] exp);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.b0 = b0; v.d0 = d0;
    v.r1 = r1; v.b1 = b1; v.d1 = d1; v.exp = exp;
    return v;
  endfunction

  vec_t        tbl [14];
  logic [15:0] d0l, k0l, d1l, k1l;
  int          a0_at, a1_at, acks, bursts;
  int          ackc [3];
  logic        g_first, g_second, prev_dr;

  initial begin
    // single legal write, then a rejected bank-7 write from requester 1
    tbl[0]  = row(1, 0, 0, 8'h00, 0, 0, 8'h00, ev(0,0,0,0,0,0,0,8'h00));
    tbl[1]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(0,0,0,0,1,0,2,8'h5A));
    tbl[2]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(1,0,0,0,1,0,2,8'h5A));
    tbl[3]  = row(0, 1, 1, 8'hFF, 1, 4, 8'h99, ev(1,0,0,0,1,0,2,8'h5A));
    tbl[4]  = row(0, 0, 1, 8'hFF, 0, 0, 8'h00, ev(0,0,0,0,1,0,2,8'h5A));
    tbl[5]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(0,0,0,0,1,0,2,8'h5A));
    tbl[6]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(0,0,0,0,1,0,2,8'h5A));
    tbl[7]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(0,0,0,0,1,0,2,8'h5A));
    tbl[8]  = row(0, 1, 2, 8'h5A, 0, 0, 8'h00, ev(0,1,0,0,1,0,2,8'h5A));
    tbl[9]  = row(0, 0, 2, 8'h5A, 0, 0, 8'h00, ev(0,0,0,0,0,0,2,8'h5A));
    tbl[10] = row(0, 0, 0, 8'h00, 1, 7, 8'h33, ev(0,0,0,0,1,1,7,8'h33));
    tbl[11] = row(0, 0, 0, 8'h00, 1, 7, 8'h33, ev(0,0,1,1,1,1,7,8'h33));
    tbl[12] = row(0, 0, 0, 8'h00, 0, 7, 8'h33, ev(0,0,0,0,0,1,7,8'h33));
    tbl[13] = row(0, 0, 0, 8'h00, 0, 0, 8'h00, ev(0,0,0,0,0,1,7,8'h33));

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      req0 = tbl[i].r0; bank0 = tbl[i].b0; data0 = tbl[i].d0;
      req1 = tbl[i].r1; bank1 = tbl[i].b1; data1 = tbl[i].d1;
      cyc();
      check($sformatf("vec%0d", i), 32'(out_v[0]), 32'(tbl[i].exp));
    end

    // both request right after reset: requester 0 first, then 1 during 0's cooldown
    do_reset();
    req0 = 1; bank0 = 1; data0 = 8'h11;
    req1 = 1; bank1 = 3; data1 = 8'h22;
    a0_at = -1; a1_at = -1; g_first = 1'bx; g_second = 1'bx;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      if (c == 1)  g_first  = bus0.grant;
      if (c == 10) g_second = bus0.grant;
      if (bus0.ack0 && a0_at < 0) begin a0_at = c; req0 = 0; end
      if (bus0.ack1 && a1_at < 0) begin a1_at = c; req1 = 0; end
    end
    check("tie_ack0_cycle", a0_at, 8);
    check("tie_ack1_cycle", a1_at, 17);
    check("tie_grant_first", g_first, 0);
    check("tie_grant_second", g_second, 1);

    // reset during STROBE aborts; held req0 is served again from scratch
    do_reset();
    req0 = 1; bank0 = 4; data0 = 8'hC3; req1 = 0;
    cyc(); cyc();
    check("pre_rst_strobe", bus0.data_ready, 1);
    rst = 1;
    cyc();
    rst = 0;
    check("rst_dr", bus0.data_ready, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_ack0", bus0.ack0, 0);
    d0l = '0; k0l = '0; d1l = '0; k1l = '0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      d0l[c] = bus0.data_ready; k0l[c] = bus0.ack0;
      d1l[c] = bus1.data_ready; k1l[c] = bus1.ack0;
      if (c == 8) req0 = 0;
    end
    check("rerun_dr_c1", d0l[1], 0);
    check("rerun_dr_c2", d0l[2], 1);
    check("rerun_dr_c3", d0l[3], 1);
    check("rerun_dr_c4", d0l[4], 0);
    check("rerun_ack_c7", k0l[7], 0);
    check("rerun_ack_c8", k0l[8], 1);
    check("short_dr_c2", d1l[2], 1);
    check("short_dr_c3", d1l[3], 0);
    check("short_ack_c2", k1l[2], 0);
    check("short_ack_c3", k1l[3], 1);

    // req0 held across back-to-back writes: one burst per ack, 10-cycle period
    do_reset();
    req0 = 1; bank0 = 5; data0 = 8'h7E; req1 = 0;
    acks = 0; bursts = 0; prev_dr = 0;
    ackc[0] = -1; ackc[1] = -1; ackc[2] = -1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (bus0.data_ready && !prev_dr) bursts++;
      prev_dr = bus0.data_ready;
      if (bus0.ack0) begin
        if (acks < 3) ackc[acks] = c;
        acks++;
      end
    end
    check("held_acks", acks, 3);
    check("held_bursts", bursts, 3);
    check("held_ack1_cycle", ackc[0], 8);
    check("held_ack2_cycle", ackc[1], 18);
    check("held_ack3_cycle", ackc[2], 28);

    // random traffic, including illegal banks, mid-transaction input churn and resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req0 = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) req1 = ($urandom_range(0, 9) < 7);
      if (!req0 || $urandom_range(0, 15) == 0) begin
        bank0 = 3'($urandom_range(0, 7)); data0 = 8'($urandom);
      end
      if (!req1 || $urandom_range(0, 15) == 0) begin
        bank1 = 3'($urandom_range(0, 7)); data1 = 8'($urandom);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_bus_arbiter.md
PARAM_BUS_ARBITER -- requirements
Module: param_bus_arbiter

Interface
REQ-001 Parameter STROBE_LEN, default 2: number of cycles data_ready is held high per write; legal range 1..15.
REQ-002 Parameter HOLD_LEN, default 4: cycles bank_adr/out_data stay stable after data_ready falls; legal range 0..15.
REQ-003 Parameter MAX_BANK, default 5: highest legal bank address; banks above it are rejected.
REQ-004 CLOCK_25  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  requester 0 (MIDI SysEx parser) write request; level, held until ack0.
REQ-007 bank0  input  3  requester 0 bank address, stable while req0 high.
REQ-008 data0  input  8  requester 0 write data, stable while req0 high.
REQ-009 req1 / bank1 / data1  input  1 / 3 / 8  requester 1 (host interface); same rules as requester 0.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 err  output  1  one-cycle pulse coinciding with ack when the transaction was rejected.
REQ-012 data_ready  output  1  write strobe to the bank address decoder / parameter bus.
REQ-013 bank_adr  output  3  registered bank address driven to the decoder.
REQ-014 out_data  output  8  registered write data driven to the parameter bus.
REQ-015 grant  output  1  index of the requester owning the current or last transaction.
REQ-016 busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-017 State machine SHALL have states IDLE, SETUP, STROBE, HOLD, DONE, REJECT; all outputs registered.
REQ-018 IDLE: no req -> stay; exactly one eligible req -> grant it; both eligible -> grant the requester not equal to last grant (round robin).
REQ-019 On leaving IDLE, bank_adr, out_data and grant SHALL load from the granted requester in the same edge; they are then frozen until the next grant.
REQ-020 Granted bank > MAX_BANK -> REJECT for 1 cycle: ack and err pulse high, data_ready never asserted, then IDLE.
REQ-021 Legal bank -> SETUP for exactly 1 cycle (data_ready low), then STROBE.
REQ-022 STROBE: data_ready high for exactly STROBE_LEN consecutive cycles, then HOLD (or DONE if HOLD_LEN = 0).
REQ-023 HOLD: data_ready low for exactly HOLD_LEN cycles, then DONE.
REQ-024 DONE: ack of granted requester high 1 cycle, then IDLE.
REQ-025 Latency, defaults: req sampled in IDLE at cycle 0 -> data_ready high cycles 2-3 -> ack at cycle 8; generally ack at cycle 2+STROBE_LEN+HOLD_LEN.
REQ-026 The requester acked in the previous cycle SHALL be ineligible in the first IDLE cycle (one-cycle cooldown), so a req dropped after ack never double-writes.
REQ-027 A 4-bit down-counter SHALL time STROBE and HOLD; it loads on state entry and never wraps below zero.
REQ-028 req changes or deassertion during a granted transaction SHALL be ignored; the transaction completes with latched values.
REQ-029 Only one of ack0/ack1 SHALL ever be high in a cycle; ack and data_ready are never high together.

Reset
REQ-030 reset high at any edge SHALL force IDLE; data_ready, ack0, ack1, err, busy, bank_adr, out_data, grant = 0 after that edge; last grant = 1 so requester 0 wins the first tie.
REQ-031 Reset mid-transaction SHALL abort it with no ack; requesters still holding req are re-arbitrated after reset releases.

Verification
REQ-032 req0 bank0=2 data0=0x5A single -> bank_adr=2, out_data=0x5A one edge later; data_ready high cycles 2-3; ack0 at cycle 8; err=0.
REQ-033 req0 and req1 both high after reset -> requester 0 served first, requester 1 granted in the IDLE cycle after the ack0 cooldown; grant toggles 0->1.
REQ-034 req1 bank1=7 -> ack1 and err high together at cycle 2; data_ready stays 0; bank_adr=7 visible, no strobe.
REQ-035 reset asserted during STROBE -> data_ready=0 and busy=0 next edge, no ack0; held req0 re-served from cycle 0 after reset release.
REQ-036 STROBE_LEN=1, HOLD_LEN=0 build -> data_ready high exactly cycle 2, ack at cycle 3.
REQ-037 req0 held continuously across 3 transactions with req1 idle -> exactly one data_ready burst per ack0, separated by the one-cycle cooldown.
